// File: rtl/waited_dual_port_memory.sv
// waited_dual_port_memory
//   Two-port word memory with per-port req/ready handshake and a fixed
//   wait-state latency. Port I is read-only (instruction fetch); port D is
//   read/write with byte-lane enables (data). Reads are read-first: a write
//   returns the word as it was before the write. Storage is split into BYTES
//   8-bit lane arrays so a byte-enabled block RAM can be inferred. The arrays
//   have no reset and rely on the zero power-up state of the RAM/simulator.
//
//   Optional build macro: MEM_MISALIGN_ERR_EN adds d_err and rejects
//   full-word writes whose byte offset is non-zero.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_req/i_addr      port I read request and byte address
//   i_data/i_ready    port I read data, one-cycle completion pulse
//   d_req/d_we        port D request, byte-lane write enables (0 = read)
//   d_addr/d_wdata    port D byte address and write data
//   d_rdata/d_ready   port D read data, one-cycle completion pulse
//   d_err             (MEM_MISALIGN_ERR_EN only) misaligned full-word write
//
// Per-port FSM
//   state | meaning
//   IDLE  | waiting for req; accepts and captures the request
//   WAIT  | counting down wait states
//   DONE  | ready high for one cycle, then back to IDLE
module waited_dual_port_memory #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_data,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready
`ifdef MEM_MISALIGN_ERR_EN
    ,
    output logic                  d_err
`endif
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int DEPTH  = 2 ** WIDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t              i_state_q, i_state_d, d_state_q, d_state_d;
    logic [3:0]          i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic [ADDR_W-1:0]   i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [BYTES-1:0]    d_we_q, d_we_d;
    logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;
    logic [DATA_W-1:0]   i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic                d_err_q, d_err_d;

    // The edge entering DONE is the commit edge. With LATENCY = 1 that is the
    // accepting edge itself, so the live inputs are used instead of the
    // holding registers while still in IDLE.
    logic                i_commit, d_commit, d_misalign, d_wr_en;
    logic [ADDR_W-1:0]   i_caddr, d_caddr;
    logic [BYTES-1:0]    d_cwe;
    logic [DATA_W-1:0]   d_cwdata, i_rword, d_rword;
    logic [WIDX_W-1:0]   i_widx, d_widx;

    assign i_commit = (i_state_q == ST_WAIT && i_cnt_q == 4'd1) ||
                      (i_state_q == ST_IDLE && i_req && LATENCY == 1);
    assign d_commit = (d_state_q == ST_WAIT && d_cnt_q == 4'd1) ||
                      (d_state_q == ST_IDLE && d_req && LATENCY == 1);

    assign i_caddr  = (i_state_q == ST_IDLE) ? i_addr  : i_addr_q;
    assign d_caddr  = (d_state_q == ST_IDLE) ? d_addr  : d_addr_q;
    assign d_cwe    = (d_state_q == ST_IDLE) ? d_we    : d_we_q;
    assign d_cwdata = (d_state_q == ST_IDLE) ? d_wdata : d_wdata_q;

    assign i_widx = WIDX_W'(i_caddr >> OFF_W);
    assign d_widx = WIDX_W'(d_caddr >> OFF_W);

`ifdef MEM_MISALIGN_ERR_EN
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    assign d_misalign = (d_cwe == '1) && ((d_caddr & OFF_MASK) != '0);
    assign d_err      = d_err_q;
`else
    assign d_misalign = 1'b0;
`endif

    // rst gate keeps a LATENCY=1 request seen during reset from writing.
    assign d_wr_en = d_commit && (d_cwe != '0) && !d_misalign && !rst;

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (d_wr_en && d_cwe[k]) begin
                mem[d_widx] <= d_cwdata[8*k +: 8];
            end
        end

        assign i_rword[8*k +: 8] = mem[i_widx];
        assign d_rword[8*k +: 8] = mem[d_widx];
    end

    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        case (i_state_q)
            ST_IDLE: begin
                if (i_req) begin
                    i_addr_d  = i_addr;
                    i_cnt_d   = CNT_LOAD;
                    i_state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                i_cnt_d = i_cnt_q - 4'd1;
                if (i_cnt_q == 4'd1) i_state_d = ST_DONE;
            end
            default: i_state_d = ST_IDLE;
        endcase
        i_ready_d = i_commit;
        i_data_d  = i_commit ? i_rword : i_data_q;
    end

    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_addr_d  = d_addr_q;
        d_we_d    = d_we_q;
        d_wdata_d = d_wdata_q;
        case (d_state_q)
            ST_IDLE: begin
                if (d_req) begin
                    d_addr_d  = d_addr;
                    d_we_d    = d_we;
                    d_wdata_d = d_wdata;
                    d_cnt_d   = CNT_LOAD;
                    d_state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                d_cnt_d = d_cnt_q - 4'd1;
                if (d_cnt_q == 4'd1) d_state_d = ST_DONE;
            end
            default: d_state_d = ST_IDLE;
        endcase
        d_ready_d = d_commit;
        d_err_d   = d_commit && d_misalign;
        // A rejected misaligned write leaves the read data untouched.
        d_rdata_d = (d_commit && !d_misalign) ? d_rword : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q <= ST_IDLE;
            i_cnt_q   <= '0;
            i_addr_q  <= '0;
            i_data_q  <= '0;
            i_ready_q <= 1'b0;
            d_state_q <= ST_IDLE;
            d_cnt_q   <= '0;
            d_addr_q  <= '0;
            d_we_q    <= '0;
            d_wdata_q <= '0;
            d_rdata_q <= '0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_addr_q  <= i_addr_d;
            i_data_q  <= i_data_d;
            i_ready_q <= i_ready_d;
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_addr_q  <= d_addr_d;
            d_we_q    <= d_we_d;
            d_wdata_q <= d_wdata_d;
            d_rdata_q <= d_rdata_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
        end
    end

    assign i_data  = i_data_q;
    assign i_ready = i_ready_q;
    assign d_rdata = d_rdata_q;
    assign d_ready = d_ready_q;

endmodule

// File: doc/waited_dual_port_memory.md
Name: waited_dual_port_memory

Overview:
- Parameterised two-port memory for the LC-3b datapath.
- Port I is read-only, used for instruction fetch. Port D is read/write with byte-lane write enables, used for data.
- Each port has an independent req/ready handshake and a programmable wait-state latency, so the control store can model slow memory (MIO_EN / R handshake).
- Generalises the fixed 16-bit, single-cycle two-port memory in width, depth and latency, and adds ready signalling per port.

Parameters:
- DATA_W, 16, word width in bits; multiple of 8; BYTES = DATA_W/8 (power of two).
- ADDR_W, 16, byte-address width; word index = addr[ADDR_W-1:log2(BYTES)]; DEPTH = 2^(ADDR_W-log2(BYTES)).
- LATENCY, 3, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  port I read request; held high until i_ready.
- i_addr  in  ADDR_W  port I byte address.
- i_data  out  DATA_W  port I read data.
- i_ready  out  1  port I access complete (one-cycle pulse).
- d_req  in  1  port D request; held high until d_ready.
- d_we  in  BYTES  port D byte-lane write enables; all zero means read.
- d_addr  in  ADDR_W  port D byte address.
- d_wdata  in  DATA_W  port D write data; lane k = d_wdata[8k+7:8k].
- d_rdata  out  DATA_W  port D read data.
- d_ready  out  1  port D access complete (one-cycle pulse).

Behaviour:
- Reset (async, active-high):
  - Both port FSMs go to IDLE; counters go to 0.
  - i_ready = d_ready = 0; i_data = d_rdata = 0.
  - Array contents are not reset; the array is initialised to zero at time 0 only.
- Per-port FSM (ports fully independent): states IDLE, WAIT, DONE.
  - IDLE: on a clk edge with req = 1, capture addr, d_we and d_wdata into holding registers and load count = LATENCY-1.
    - If LATENCY = 1, go straight to DONE; otherwise go to WAIT.
  - WAIT: decrement count each cycle; when count = 1, transition to DONE.
  - DONE: ready = 1 for exactly one cycle. Data output updated on the same edge that enters DONE. Next state is always IDLE.
- Latency:
  - req first seen high at edge N → ready high in the cycle after edge N+LATENCY-1.
  - Minimum spacing between accesses on one port is LATENCY+1 cycles.
  - req is ignored in WAIT and DONE.
  - Captured values are used for the whole access; input changes after acceptance have no effect.
- Read:
  - Data output = array[captured word index], sampled on the edge entering DONE.
  - Output holds that value until the next completed access or reset.
- Write (port D, any d_we bit set):
  - Only lanes with d_we[k] = 1 are written; other lanes are unchanged.
  - Commits on the edge entering DONE.
  - d_rdata on a write returns the pre-write word (read-first).
- Address low bits (byte offset) are ignored for word selection.
- Collision: port I and port D target the same word on the same committing edge.
  - Port I returns the old data.
  - The write still commits.
- Reset mid-access:
  - The access is aborted and no ready is produced.
  - A write whose DONE edge has not occurred is not committed.
- Storage: BYTES separate 8-bit arrays of DEPTH entries each, so synthesis infers block RAM with byte enables.

Optional Feature:
- Macro MEM_MISALIGN_ERR_EN.
- When defined:
  - Adds output port d_err (1 bit), reset to 0.
  - A port D access is misaligned when the captured byte offset != 0 and d_we is all ones (full-word write).
  - A misaligned access completes with normal latency, but no write is performed, d_err = 1 together with d_ready, and d_rdata is unchanged.
  - d_err is 0 in every other cycle.
- When not defined:
  - No d_err port.
  - Byte offset is ignored and full-word writes go to the word index.

Test Plan (DATA_W=16, ADDR_W=16, LATENCY=3 unless stated):
- Reset: assert rst asynchronously mid-cycle → i_ready, d_ready, i_data and d_rdata are 0 immediately. Release rst, then i_req=1 with i_addr=0x0000 → i_ready pulses exactly 3 cycles after acceptance and i_data=0x0000.
- Full-word write: d_we=2'b11, d_addr=0x1234, d_wdata=0xBEEF, then read 0x1234 on port I → i_data=0xBEEF. The write access returns d_rdata=0x0000 (read-first).
- Byte write: d_we=2'b01, d_addr=0x1234, d_wdata=0x00AA → port D read of 0x1235 returns 0xBEAA.
- Collision: port I read and port D write of 0xCAFE to word 0x0040, both requested on the same edge → i_data returns the old value. A following read returns 0xCAFE. Each ready is 1 cycle wide.
- Mid-access reset, LATENCY=4: pulse rst during WAIT of a write of 0x5555 to 0x0010 → no d_ready, and a later read of 0x0010 returns the prior contents. Also with LATENCY=1: req at edge N → ready in the cycle after edge N.
- With MEM_MISALIGN_ERR_EN: d_we=2'b11, d_addr=0x0021 → d_err=1 with d_ready, and word 0x0020 is unchanged. Without the macro, the same access writes word 0x0020.
